// File: rtl/alu_cu_pkg.sv
// ALU control unit shared types and constants.
// Select codes, op classes, funct codes, decode helper.
package alu_cu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOI_MEM = 2'b00;
  localparam logic [1:0] AOI_BR  = 2'b01;
  localparam logic [1:0] AOI_RT  = 2'b10;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0100;
  localparam logic [3:0] F_OR  = 4'b0101;
  localparam logic [3:0] F_SLT = 4'b1010;

  typedef struct packed {
    logic [2:0] op;
    logic       illegal;
  } dec_t;

  function automatic dec_t rt_decode(
    input logic [3:0] fc,
    input logic [2:0] dflt
  );
    dec_t d;
    d.op      = dflt;
    d.illegal = 1'b0;
    unique case (fc)
      F_ADD:   d.op = ALU_ADD;
      F_SUB:   d.op = ALU_SUB;
      F_AND:   d.op = ALU_AND;
      F_OR:    d.op = ALU_OR;
      F_SLT:   d.op = ALU_SLT;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_cu_decode.sv
// ALU control combinational decode.
// (aoi, functionCode) -> (op, illegal).
module alu_cu_decode
  import alu_cu_pkg::*;
#(
  parameter logic [2:0] DEFAULT_OP = 3'b010
) (
  input  logic [1:0] aoi,
  input  logic [3:0] functionCode,
  output logic [2:0] op,
  output logic       illegal
);

  dec_t d;

  // Class first; only R-type looks at functionCode.
  always_comb begin
    d.op      = ALU_ADD;
    d.illegal = 1'b0;
    unique case (1'b1)
      aoi[1]:
        d = rt_decode(functionCode, DEFAULT_OP);
      (aoi == AOI_BR):
        d.op = ALU_SUB;
      default:
        d.op = ALU_ADD;
    endcase
  end

  assign op      = d.op;
  assign illegal = d.illegal;

endmodule

// File: rtl/alu_cu.sv
// ALU control unit top.
// Registered decode result plus saturating error count.
module alu_cu
  import alu_cu_pkg::*;
#(
  parameter int         ERR_CNT_W  = 8,
  parameter logic [2:0] DEFAULT_OP = 3'b010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           aoi,
  input  logic [3:0]           functionCode,
  input  logic                 in_valid,
  output logic [2:0]           op,
  output logic                 out_valid,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [2:0] dop;
  logic       dill;

  alu_cu_decode #(
    .DEFAULT_OP (DEFAULT_OP)
  ) u_dec (
    .aoi          (aoi),
    .functionCode (functionCode),
    .op           (dop),
    .illegal      (dill)
  );

  // Output stage: op holds when idle, flags drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= ALU_ADD;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      illegal   <= in_valid & dill;
      if (in_valid)
        op <= dop;
    end
  end

  // Illegal counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (in_valid && dill && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_cu.sv
// Directed bench for alu_cu.
// Second instance with 2-bit counter for saturation.
module tb_alu_cu;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [1:0] aoi;
  logic [3:0] fc;
  logic       in_valid;
  logic [2:0] op, op2;
  logic       ov, ov2, ill, ill2;
  logic [7:0] err;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cu u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .aoi          (aoi),
    .functionCode (fc),
    .in_valid     (in_valid),
    .op           (op),
    .out_valid    (ov),
    .illegal      (ill),
    .err_count    (err)
  );

  alu_cu #(.ERR_CNT_W(2)) u_sat (
    .clk          (clk),
    .rst_n        (rst2_n),
    .aoi          (aoi),
    .functionCode (fc),
    .in_valid     (in_valid),
    .op           (op2),
    .out_valid    (ov2),
    .illegal      (ill2),
    .err_count    (err2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(
    input logic [1:0] a,
    input logic [3:0] f,
    input logic       v
  );
    aoi      = a;
    fc       = f;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fcs [5] = '{4'b0000, 4'b0010,
                          4'b0100, 4'b0101, 4'b1010};
  logic [2:0] ops [5] = '{3'b010, 3'b110,
                          3'b000, 3'b001, 3'b111};

  initial begin
    rst_n    = 1'b0;
    rst2_n   = 1'b0;
    aoi      = 2'b10;
    fc       = 4'b1000;
    in_valid = 1'b0;
    // reset held while requests toggle
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 4'b1000, i[0]);
      chk("rst_op", op, 3'b010);
      chk("rst_ov", ov, 1'b0);
      chk("rst_ill", ill, 1'b0);
      chk("rst_err", err, 8'd0);
    end
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    step(2'b00, 4'b0000, 1'b0);
    chk("idle_ov", ov, 1'b0);

    // mem / branch classes
    step(2'b00, 4'b1111, 1'b1);
    chk("mem_op", op, 3'b010);
    chk("mem_ov", ov, 1'b1);
    chk("mem_ill", ill, 1'b0);
    step(2'b01, 4'b1111, 1'b1);
    chk("br_op", op, 3'b110);
    chk("br_ill", ill, 1'b0);

    // R-type back to back
    for (int i = 0; i < 5; i++) begin
      step(2'b10, fcs[i], 1'b1);
      chk($sformatf("rt_op%0d", i), op, ops[i]);
      chk($sformatf("rt_ov%0d", i), ov, 1'b1);
      chk($sformatf("rt_ill%0d", i), ill, 1'b0);
    end
    step(2'b11, 4'b0010, 1'b1);
    chk("rt11_op", op, 3'b110);

    // unsupported funct
    step(2'b10, 4'b1000, 1'b1);
    chk("bad_op", op, 3'b010);
    chk("bad_ill", ill, 1'b1);
    chk("bad_err", err, 8'd1);
    step(2'b01, 4'b1000, 1'b1);
    chk("brbad_op", op, 3'b110);
    chk("brbad_ill", ill, 1'b0);
    chk("brbad_err", err, 8'd1);

    // idle after SUB
    step(2'b10, 4'b0000, 1'b0);
    chk("hold_ov", ov, 1'b0);
    chk("hold_op", op, 3'b110);
    chk("hold_ill", ill, 1'b0);

    // saturation on 2-bit counter
    rst2_n = 1'b0;
    #1;
    chk("sat_clr", err2, 2'd0);
    rst2_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 4'b1111, 1'b1);
      chk($sformatf("sat%0d", i), err2,
          (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("cnt%0d", i), err, 32'(i + 2));
    end
    // async reset mid-burst
    rst2_n = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_sat", err2, 2'd0);
    chk("mid_err", err, 8'd0);
    chk("mid_op", op, 3'b010);
    chk("mid_ov", ov, 1'b0);
    chk("mid_ill", ill, 1'b0);
    step(2'b11, 4'b1111, 1'b1);
    chk("held_sat", err2, 2'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    step(2'b10, 4'b0100, 1'b1);
    chk("rel_ov", ov, 1'b1);
    chk("rel_op", op, 3'b000);
    chk("rel_err", err, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
